// File: rtl/paint_grid_tracker.sv
// rtl/paint_grid_tracker.sv - button-driven cell painter with incremental count and 2-cycle video lookup
module paint_grid_tracker #(
    parameter int HCELLS    = 80,
    parameter int VCELLS    = 60,
    parameter int CELL_LOG2 = 3,
    parameter int HW        = 11,
    parameter int VW        = 10,
    parameter int CNT_W     = 13,
    localparam int XW       = $clog2(HCELLS),
    localparam int YW       = $clog2(VCELLS)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [4:0]                 btn,
    input  logic                       clr,
    input  logic [HW-1:0]              hcnt,
    input  logic [VW-1:0]              vcnt,
    output logic                       on,
    output logic                       cursor_hit,
    output logic [XW-1:0]              cursor_x,
    output logic [YW-1:0]              cursor_y,
    output logic                       pen,
    output logic                       busy,
    output logic [CNT_W-1:0]           cell_cnt,
    output logic [CNT_W+2*CELL_LOG2-1:0] pixel_cnt
);

    localparam int NCELLS = HCELLS * VCELLS;
    localparam int AW     = $clog2(NCELLS + 1);
    localparam int CXW    = HW - CELL_LOG2;
    localparam int CYW    = VW - CELL_LOG2;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_WR} state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;
    logic [4:0]      btn_s1, btn_s2, btn_prev, press;
    logic            old_bit;
    logic [AW-1:0]   cur_addr;
    logic            we, wdata;
    logic [AW-1:0]   waddr;
    logic            mem [0:NCELLS-1];

    logic [CXW-1:0]  cx;
    logic [CYW-1:0]  cy;
    logic [AW-1:0]   vid_addr;
    logic            vid_in_range, vid_cur;
    logic            unused_ok;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign press    = btn_s2 & ~btn_prev;
    assign cur_addr = AW'(cursor_y) * AW'(HCELLS) + AW'(cursor_x);

    // Sweep address NCELLS is the finalize step: no write, just the count reset.
    always_comb begin
        we    = 1'b0;
        waddr = cur_addr;
        wdata = 1'b0;
        if (!RESET) begin
            if (state == S_CLEAR && clr_addr != AW'(NCELLS)) begin
                we    = 1'b1;
                waddr = clr_addr;
            end else if (state == S_WR) begin
                we    = 1'b1;
                wdata = pen;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            pen      <= 1'b1;
            cell_cnt <= '0;
            old_bit  <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == AW'(NCELLS)) begin
                        cell_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clr) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end else if (|press) begin
                        state <= S_RD;
                        if (press[0])
                            cursor_x <= (cursor_x == XW'(HCELLS-1)) ? '0 : cursor_x + 1'b1;
                        else if (press[1])
                            cursor_x <= (cursor_x == '0) ? XW'(HCELLS-1) : cursor_x - 1'b1;
                        else if (press[2])
                            cursor_y <= (cursor_y == '0) ? YW'(VCELLS-1) : cursor_y - 1'b1;
                        else if (press[3])
                            cursor_y <= (cursor_y == YW'(VCELLS-1)) ? '0 : cursor_y + 1'b1;
                        else
                            pen <= ~pen;
                    end
                end
                S_RD: begin
                    old_bit <= mem[cur_addr];
                    state   <= S_WR;
                end
                S_WR: begin
                    if (!old_bit && pen)
                        cell_cnt <= cell_cnt + 1'b1;
                    else if (old_bit && !pen)
                        cell_cnt <= cell_cnt - 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign pixel_cnt = {cell_cnt, {(2*CELL_LOG2){1'b0}}};

    assign cx        = hcnt[HW-1:CELL_LOG2];
    assign cy        = vcnt[VW-1:CELL_LOG2];
    assign unused_ok = ^{hcnt[CELL_LOG2-1:0], vcnt[CELL_LOG2-1:0]};

    // Stage 2 reads the bitmap before any same-edge write lands, so video sees old data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vid_addr     <= '0;
            vid_in_range <= 1'b0;
            vid_cur      <= 1'b0;
            on           <= 1'b0;
            cursor_hit   <= 1'b0;
        end else begin
            vid_addr     <= AW'(cy) * AW'(HCELLS) + AW'(cx);
            vid_in_range <= (cx < CXW'(HCELLS)) && (cy < CYW'(VCELLS));
            vid_cur      <= (cx == CXW'(cursor_x)) && (cy == CYW'(cursor_y));
            on           <= vid_in_range & mem[vid_addr];
            cursor_hit   <= vid_in_range & vid_cur;
        end
    end

endmodule

// File: tb/tb_paint_grid_tracker.sv
// tb/tb_paint_grid_tracker.sv - randomized bench for paint_grid_tracker against a bitmap model
module tb_paint_grid_tracker;

    localparam int H = 80;
    localparam int V = 60;
    localparam int N = H * V;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  btn = '0;
    logic        clr = 1'b0;
    logic [10:0] hcnt = '0;
    logic [9:0]  vcnt = '0;
    logic        on, cursor_hit, pen, busy;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [12:0] cell_cnt;
    logic [18:0] pixel_cnt;

    int vectors = 0;
    int miscompares = 0;

    bit mdl [V][H];
    int mx, my;
    bit mpen;

    typedef struct { bit e_on; bit e_hit; int h; int v; } pix_t;

    paint_grid_tracker dut (
        .CLK(CLK), .RESET(RESET), .btn(btn), .clr(clr), .hcnt(hcnt), .vcnt(vcnt),
        .on(on), .cursor_hit(cursor_hit), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .pen(pen), .busy(busy), .cell_cnt(cell_cnt), .pixel_cnt(pixel_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int mdl_count();
        int s = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                s += mdl[y][x];
        return s;
    endfunction

    function automatic bit exp_on(int h, int v);
        int cx = h / 8;
        int cy = v / 8;
        if (cx >= H || cy >= V) return 1'b0;
        return mdl[cy][cx];
    endfunction

    function automatic bit exp_hit(int h, int v);
        int cx = h / 8;
        int cy = v / 8;
        if (cx >= H || cy >= V) return 1'b0;
        return (cx == mx) && (cy == my);
    endfunction

    task automatic model_clear();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                mdl[y][x] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        mx = 0; my = 0; mpen = 1'b1;
    endtask

    task automatic model_press(input logic [4:0] m);
        if (m == 5'd0) return;
        if (m[0])      mx = (mx + 1) % H;
        else if (m[1]) mx = (mx + H - 1) % H;
        else if (m[2]) my = (my + V - 1) % V;
        else if (m[3]) my = (my + 1) % V;
        else           mpen = !mpen;
        mdl[my][mx] = mpen;
    endtask

    task automatic do_reset(output int fall);
        btn = '0; clr = 1'b0;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); @(negedge CLK); RESET = 1'b0;
        fall = 0;
        for (int k = 1; k <= N + 100; k++) begin
            @(posedge CLK); #1;
            if (!busy) begin fall = k; break; end
        end
        model_reset();
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge CLK); btn = m;
        @(negedge CLK); btn = '0;
        repeat (5) @(negedge CLK);
        model_press(m);
    endtask

    task automatic probe(input int h, input int v, output logic o_on, output logic o_hit);
        @(negedge CLK); hcnt = h[10:0]; vcnt = v[9:0];
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        o_on = on; o_hit = cursor_hit;
    endtask

    task automatic test_video_scan();
        pix_t q[$];
        pix_t p, e;
        int total = N + 64;
        for (int k = 0; k < total + 2; k++) begin
            @(negedge CLK);
            if (k >= 2) begin
                e = q.pop_front();
                vectors++; if (on !== e.e_on) begin miscompares++; $display("FAIL scan_on h=%0d v=%0d: got %b expected %b", e.h, e.v, on, e.e_on); end
                vectors++; if (cursor_hit !== e.e_hit) begin miscompares++; $display("FAIL scan_hit h=%0d v=%0d: got %b expected %b", e.h, e.v, cursor_hit, e.e_hit); end
            end
            if (k < total) begin
                if (k < N) begin
                    p.h = (k % H) * 8 + int'($urandom_range(0, 7));
                    p.v = (k / H) * 8 + int'($urandom_range(0, 7));
                end else begin
                    p.h = int'($urandom_range(0, 2047));
                    p.v = int'($urandom_range(0, 1023));
                end
                p.e_on = exp_on(p.h, p.v);
                p.e_hit = exp_hit(p.h, p.v);
                hcnt = p.h[10:0]; vcnt = p.v[9:0];
                q.push_back(p);
            end
        end
    endtask

    task automatic test_reset();
        int fall;
        @(negedge CLK);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %b expected 1", busy); end
        vectors++; if (on !== 1'b0 || cursor_hit !== 1'b0) begin miscompares++; $display("FAIL rst_video: got on=%b hit=%b expected 0 0", on, cursor_hit); end
        vectors++; if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin miscompares++; $display("FAIL rst_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y); end
        vectors++; if (pen !== 1'b1 || cell_cnt !== 13'd0) begin miscompares++; $display("FAIL rst_pen_cnt: got pen=%b cnt=%0d expected 1 0", pen, cell_cnt); end
        do_reset(fall);
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL rst_sweep_len: got %0d expected %0d", fall, N + 1); end
        vectors++; if (cell_cnt !== 13'd0 || pixel_cnt !== 19'd0) begin miscompares++; $display("FAIL rst_cnt_after: got %0d/%0d expected 0/0", cell_cnt, pixel_cnt); end
        test_video_scan();
    endtask

    task automatic test_right();
        logic o_on, o_hit;
        int v;
        @(negedge CLK); btn = 5'b00001;
        @(posedge CLK); #1 btn = '0;
        @(posedge CLK); #1;
        vectors++; if (cursor_x !== 7'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL lat_t1: got x=%0d busy=%b expected 0 0", cursor_x, busy); end
        @(posedge CLK); #1;
        vectors++; if (cursor_x !== 7'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL lat_t2: got x=%0d busy=%b expected 1 1", cursor_x, busy); end
        @(posedge CLK); #1;
        vectors++; if (busy !== 1'b1 || cell_cnt !== 13'd0) begin miscompares++; $display("FAIL lat_t3: got busy=%b cnt=%0d expected 1 0", busy, cell_cnt); end
        @(posedge CLK); #1;
        vectors++; if (busy !== 1'b0 || cell_cnt !== 13'd1) begin miscompares++; $display("FAIL lat_t4: got busy=%b cnt=%0d expected 0 1", busy, cell_cnt); end
        model_press(5'b00001);
        repeat (3) @(negedge CLK);
        press(5'b00001);
        press(5'b00001);
        vectors++; if (cursor_x !== 7'd3 || cursor_y !== 6'd0) begin miscompares++; $display("FAIL right3_cursor: got (%0d,%0d) expected (3,0)", cursor_x, cursor_y); end
        vectors++; if (cell_cnt !== 13'd3) begin miscompares++; $display("FAIL right3_cnt: got %0d expected 3", cell_cnt); end
        vectors++; if (pixel_cnt !== 19'd192) begin miscompares++; $display("FAIL right3_pix: got %0d expected 192", pixel_cnt); end
        for (int h = 0; h <= 33; h++) begin
            v = int'($urandom_range(0, 7));
            probe(h, v, o_on, o_hit);
            vectors++; if (o_on !== (h >= 8 && h <= 31)) begin miscompares++; $display("FAIL right3_on h=%0d v=%0d: got %b expected %b", h, v, o_on, (h >= 8 && h <= 31)); end
            vectors++; if (o_hit !== (h >= 24 && h <= 31)) begin miscompares++; $display("FAIL right3_hit h=%0d: got %b expected %b", h, o_hit, (h >= 24 && h <= 31)); end
        end
        probe(16, 8, o_on, o_hit);
        vectors++; if (o_on !== 1'b0) begin miscompares++; $display("FAIL right3_row1: got %b expected 0", o_on); end
    endtask

    task automatic test_left_up();
        int fall;
        logic o_on, o_hit;
        do_reset(fall);
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL lu_sweep_len: got %0d expected %0d", fall, N + 1); end
        press(5'b00010);
        vectors++; if (cursor_x !== 7'd79 || cursor_y !== 6'd0) begin miscompares++; $display("FAIL left_wrap: got (%0d,%0d) expected (79,0)", cursor_x, cursor_y); end
        press(5'b00100);
        vectors++; if (cursor_x !== 7'd79 || cursor_y !== 6'd59) begin miscompares++; $display("FAIL up_wrap: got (%0d,%0d) expected (79,59)", cursor_x, cursor_y); end
        vectors++; if (cell_cnt !== 13'd2) begin miscompares++; $display("FAIL lu_cnt: got %0d expected 2", cell_cnt); end
        probe(639, 479, o_on, o_hit);
        vectors++; if (o_on !== 1'b1 || o_hit !== 1'b1) begin miscompares++; $display("FAIL corner_in: got on=%b hit=%b expected 1 1", o_on, o_hit); end
        probe(645, 479, o_on, o_hit);
        vectors++; if (o_on !== 1'b0 || o_hit !== 1'b0) begin miscompares++; $display("FAIL corner_out: got on=%b hit=%b expected 0 0", o_on, o_hit); end
        probe(639, 0, o_on, o_hit);
        vectors++; if (o_on !== 1'b1 || o_hit !== 1'b0) begin miscompares++; $display("FAIL corner_top: got on=%b hit=%b expected 1 0", o_on, o_hit); end
    endtask

    task automatic test_erase();
        int fall;
        do_reset(fall);
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL er_sweep_len: got %0d expected %0d", fall, N + 1); end
        press(5'b00001);
        press(5'b00010);
        press(5'b00001);
        vectors++; if (cell_cnt !== 13'd2) begin miscompares++; $display("FAIL er_paint: got %0d expected 2", cell_cnt); end
        press(5'b10000);
        vectors++; if (pen !== 1'b0 || cell_cnt !== 13'd1) begin miscompares++; $display("FAIL er_toggle: got pen=%b cnt=%0d expected 0 1", pen, cell_cnt); end
        press(5'b00010);
        vectors++; if (cell_cnt !== 13'd0 || cursor_x !== 7'd0) begin miscompares++; $display("FAIL er_onto_painted: got cnt=%0d x=%0d expected 0 0", cell_cnt, cursor_x); end
        press(5'b01000);
        vectors++; if (cell_cnt !== 13'd0 || cursor_y !== 6'd1) begin miscompares++; $display("FAIL er_onto_blank: got cnt=%0d y=%0d expected 0 1", cell_cnt, cursor_y); end
        vectors++; if (int'(cell_cnt) != mdl_count()) begin miscompares++; $display("FAIL er_model: got %0d expected %0d", cell_cnt, mdl_count()); end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK); btn = 5'b00101;
        @(negedge CLK); btn = '0;
        @(negedge CLK); btn = 5'b00001;
        @(negedge CLK); btn = '0;
        repeat (6) @(negedge CLK);
        model_press(5'b00101);
        vectors++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin miscompares++; $display("FAIL b2b_cursor: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, mx, my); end
        vectors++; if (int'(cell_cnt) != mdl_count() || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_cnt: got %0d busy=%b expected %0d 0", cell_cnt, busy, mdl_count()); end
    endtask

    task automatic test_clear();
        int fall = 0;
        press(5'b10000);
        for (int i = 0; i < 4; i++) press(5'b00001);
        vectors++; if (cell_cnt !== 13'd5 || int'(cell_cnt) != mdl_count()) begin miscompares++; $display("FAIL clr_pre_cnt: got %0d expected 5", cell_cnt); end
        @(negedge CLK); clr = 1'b1;
        @(posedge CLK); #1 clr = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clr_rise: got %b expected 1", busy); end
        for (int k = 1; k <= N + 100; k++) begin
            @(posedge CLK); #1;
            if (!busy) begin fall = k; break; end
        end
        model_clear();
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL clr_sweep_len: got %0d expected %0d", fall, N + 1); end
        vectors++; if (cell_cnt !== 13'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d expected 0", cell_cnt); end
        vectors++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin miscompares++; $display("FAIL clr_cursor: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, mx, my); end
        test_video_scan();
    endtask

    task automatic test_reset_mid();
        int fall;
        logic o_on, o_hit;
        for (int i = 0; i < 5; i++) press(5'b00001);
        vectors++; if (cell_cnt !== 13'd5) begin miscompares++; $display("FAIL rm_pre_cnt: got %0d expected 5", cell_cnt); end
        @(negedge CLK); clr = 1'b1;
        @(posedge CLK); #1 clr = 1'b0;
        repeat (2000) @(posedge CLK);
        do_reset(fall);
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL rm_sweep_len: got %0d expected %0d", fall, N + 1); end
        vectors++; if (cell_cnt !== 13'd0 || cursor_x !== 7'd0 || pen !== 1'b1) begin miscompares++; $display("FAIL rm_state: got cnt=%0d x=%0d pen=%b expected 0 0 1", cell_cnt, cursor_x, pen); end
        @(negedge CLK); btn = 5'b00001;
        @(posedge CLK); #1 btn = '0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++; if (busy !== 1'b1 || cell_cnt !== 13'd0) begin miscompares++; $display("FAIL rw_in_wr: got busy=%b cnt=%0d expected 1 0", busy, cell_cnt); end
        RESET = 1'b1;
        #1;
        vectors++; if (cell_cnt !== 13'd0 || cursor_x !== 7'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL rw_abort: got cnt=%0d x=%0d busy=%b expected 0 0 1", cell_cnt, cursor_x, busy); end
        do_reset(fall);
        vectors++; if (fall != N + 1) begin miscompares++; $display("FAIL rw_sweep_len: got %0d expected %0d", fall, N + 1); end
        probe(8, 0, o_on, o_hit);
        vectors++; if (o_on !== 1'b0 || cell_cnt !== 13'd0) begin miscompares++; $display("FAIL rw_cell: got on=%b cnt=%0d expected 0 0", o_on, cell_cnt); end
    endtask

    task automatic test_random();
        logic [4:0] m;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) m = 5'(1 << $urandom_range(0, 4));
            else m = 5'($urandom_range(1, 31));
            press(m);
            vectors++; if (cursor_x !== 7'(mx) || cursor_y !== 6'(my)) begin miscompares++; $display("FAIL rnd_cursor m=%b: got (%0d,%0d) expected (%0d,%0d)", m, cursor_x, cursor_y, mx, my); end
            vectors++; if (pen !== mpen) begin miscompares++; $display("FAIL rnd_pen m=%b: got %b expected %b", m, pen, mpen); end
            vectors++; if (int'(cell_cnt) != mdl_count()) begin miscompares++; $display("FAIL rnd_cnt m=%b: got %0d expected %0d", m, cell_cnt, mdl_count()); end
        end
        vectors++; if (pixel_cnt !== 19'(mdl_count() * 64)) begin miscompares++; $display("FAIL rnd_pix: got %0d expected %0d", pixel_cnt, mdl_count() * 64); end
        test_video_scan();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_right();
        test_left_up();
        test_erase();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
